// File: rtl/pin_integrator.sv
// pin_integrator: per-frame pin physics sequencer (collision request, velocity merge, integration).
// Optional feature macro PIN_FRICTION_EN: apply per-frame velocity decay before integration.
`timescale 1ns/1ps
module pin_integrator #(
  parameter int SCREEN_WIDTH   = 1024,
  parameter int SCREEN_HEIGHT  = 768,
  parameter int VEL_SHIFT      = 4,
  parameter int FRICTION_SHIFT = 5,
  parameter int WAIT_TIMEOUT   = 1000000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_in,
  input  logic              load_in,
  input  logic [9:0][10:0]  init_x_in,
  input  logic [9:0][9:0]   init_y_in,
  output logic              coll_valid_out,
  input  logic              coll_done_in,
  input  logic [9:0][15:0]  coll_vx_in,
  input  logic [9:0][15:0]  coll_vy_in,
  input  logic [9:0]        coll_hit_in,
  output logic [9:0][10:0]  pins_x_out,
  output logic [9:0][9:0]   pins_y_out,
  output logic [9:0][15:0]  pins_vx_out,
  output logic [9:0][15:0]  pins_vy_out,
  output logic [9:0]        pins_down_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              timeout_out
);
  // state     | meaning
  // IDLE      | waiting for frame tick or rack load
  // REQUEST   | collision request held until coll_done_in seen low
  // WAIT_DONE | waiting for collision result or timeout
  // UPDATE    | merge and integrate pin idx_q
  // FINISH    | one-cycle frame_done_out pulse
  typedef enum logic [2:0] {IDLE, REQUEST, WAIT_DONE, UPDATE, FINISH} state_t;

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic signed [12:0] X_LIM = 13'(SCREEN_WIDTH);
  localparam logic signed [12:0] Y_LIM = 13'(SCREEN_HEIGHT);

`ifdef PIN_FRICTION_EN
  localparam bit FRIC_EN = 1'b1;
`else
  localparam bit FRIC_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [9:0][10:0]  x_q, x_d;
  logic [9:0][9:0]   y_q, y_d;
  logic [9:0][15:0]  vx_q, vx_d, vy_q, vy_d;
  logic [9:0][15:0]  cvx_q, cvx_d, cvy_q, cvy_d;
  logic [9:0]        hit_q, hit_d, down_q, down_d;
  logic              tmo_q, tmo_d;

  logic signed [15:0] vx_sel, vy_sel, vx_f, vy_f, stx, sty;
  logic signed [12:0] px_n, py_n;
  logic               x_lo, x_hi, y_lo, y_hi, oob;

  function automatic logic signed [15:0] decay(input logic signed [15:0] v);
    return FRIC_EN ? v - (v >>> FRICTION_SHIFT) : v;
  endfunction

  always_comb begin
    vx_sel = hit_q[idx_q] ? $signed(cvx_q[idx_q]) : $signed(vx_q[idx_q]);
    vy_sel = hit_q[idx_q] ? $signed(cvy_q[idx_q]) : $signed(vy_q[idx_q]);
    vx_f   = decay(vx_sel);
    vy_f   = decay(vy_sel);
    stx    = vx_f >>> VEL_SHIFT;
    sty    = vy_f >>> VEL_SHIFT;
    px_n   = $signed({2'b00, x_q[idx_q]}) + $signed(stx[12:0]);
    py_n   = $signed({3'b000, y_q[idx_q]}) + $signed(sty[12:0]);
    x_lo   = px_n < 13'sd0;
    x_hi   = px_n >= X_LIM;
    y_lo   = py_n < 13'sd0;
    y_hi   = py_n >= Y_LIM;
    oob    = x_lo | x_hi | y_lo | y_hi;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cvx_d   = cvx_q;
    cvy_d   = cvy_q;
    hit_d   = hit_q;
    down_d  = down_q;
    tmo_d   = tmo_q;
    // counter runs through REQUEST and WAIT_DONE, saturating so a stuck handshake cannot wrap it
    if ((state_q == REQUEST || state_q == WAIT_DONE) && cnt_q != CW'(WAIT_TIMEOUT))
      cnt_d = cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (load_in) begin
          x_d    = init_x_in;
          y_d    = init_y_in;
          vx_d   = '0;
          vy_d   = '0;
          down_d = '0;
        end else if (frame_in) begin
          state_d = REQUEST;
          cnt_d   = '0;
        end
      end
      REQUEST: begin
        if (!coll_done_in) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (coll_done_in) begin
          cvx_d   = coll_vx_in;
          cvy_d   = coll_vy_in;
          hit_d   = coll_hit_in;
          idx_d   = '0;
          state_d = UPDATE;
        end else if (cnt_q == CW'(WAIT_TIMEOUT)) begin
          tmo_d   = 1'b1;
          hit_d   = '0;
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        x_d[idx_q]  = x_lo ? 11'd0 : (x_hi ? 11'(SCREEN_WIDTH - 1) : px_n[10:0]);
        y_d[idx_q]  = y_lo ? 10'd0 : (y_hi ? 10'(SCREEN_HEIGHT - 1) : py_n[9:0]);
        vx_d[idx_q] = oob ? 16'd0 : vx_f;
        vy_d[idx_q] = oob ? 16'd0 : vy_f;
        if (oob || hit_q[idx_q]) down_d[idx_q] = 1'b1;
        if (idx_q == 4'd9) state_d = FINISH;
        else               idx_d   = idx_q + 4'd1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      cvx_q   <= '0;
      cvy_q   <= '0;
      hit_q   <= '0;
      down_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cvx_q   <= cvx_d;
      cvy_q   <= cvy_d;
      hit_q   <= hit_d;
      down_q  <= down_d;
      tmo_q   <= tmo_d;
    end
  end

  assign coll_valid_out = (state_q == REQUEST);
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = (state_q == FINISH);
  assign timeout_out    = tmo_q;
  assign pins_x_out     = x_q;
  assign pins_y_out     = y_q;
  assign pins_vx_out    = vx_q;
  assign pins_vy_out    = vy_q;
  assign pins_down_out  = down_q;
endmodule
